// File: rtl/sched_pkg.sv
// Shared types and helpers for the per-cycle rule scheduler.
// Conflict maps are flattened i*NRULES+j bit vectors.
package sched_pkg;

    localparam int SCHED_MAX_RULES = 32;
    localparam int SCHED_CMAP_W    = SCHED_MAX_RULES * SCHED_MAX_RULES;

    typedef logic [7:0] starve_ctr_t;

    function automatic logic [5:0] popcount(
        input logic [SCHED_MAX_RULES-1:0] v
    );
        logic [5:0] c;
        c = '0;
        for (int k = 0; k < SCHED_MAX_RULES; k++) begin
            c = c + {5'd0, v[k]};
        end
        return c;
    endfunction

    function automatic logic conflict_or(
        input logic [SCHED_CMAP_W-1:0] cm,
        input int                      n,
        input int                      i,
        input int                      j
    );
        return cm[i*n+j] | cm[j*n+i];
    endfunction

endpackage

// File: rtl/rule_starve_ctr.sv
// Per-rule starvation counter: counts ready-but-ungranted cycles,
// saturates at STARVE_LIMIT and raises a registered starved flag.
module rule_starve_ctr
    import sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 7
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_ready,
    input  logic i_grant,
    output logic o_starved
);

    localparam starve_ctr_t LIM = starve_ctr_t'(STARVE_LIMIT);

    starve_ctr_t r_ctr;
    starve_ctr_t w_ctr_nxt;
    logic        r_starved;

    always_comb begin
        w_ctr_nxt = r_ctr;
        if (i_run) begin
            if (!i_ready || i_grant) begin
                w_ctr_nxt = '0;
            end else if (r_ctr != LIM) begin
                w_ctr_nxt = r_ctr + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ctr     <= '0;
            r_starved <= 1'b0;
        end else begin
            r_ctr     <= w_ctr_nxt;
            r_starved <= (w_ctr_nxt == LIM);
        end
    end

    assign o_starved = r_starved;

endmodule

// File: rtl/rule_scheduler.sv
// Round-robin rule scheduler with conflict exclusion and starvation
// promotion; rule_enable is a same-cycle function of rule_ready.
module rule_scheduler
    import sched_pkg::*;
#(
    parameter int                     NRULES       = 4,
    parameter logic [NRULES*NRULES-1:0] CONFLICT   = '0,
    parameter int                     STARVE_LIMIT = 7,
    parameter int                     CNTW         = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              run,
    input  logic [NRULES-1:0] rule_ready,
    output logic [NRULES-1:0] rule_enable,
    output logic [NRULES-1:0] starved,
    output logic [CNTW-1:0]   fire_count
);

    localparam int PTRW = (NRULES > 1) ? $clog2(NRULES) : 1;
    localparam logic [SCHED_CMAP_W-1:0] CMAP =
        (SCHED_CMAP_W)'(CONFLICT);

    logic [PTRW-1:0]          r_rr_ptr;
    logic [CNTW-1:0]          r_fire;
    logic [NRULES-1:0]        w_starved;
    logic [NRULES*NRULES-1:0] w_cm;
    logic [NRULES-1:0]        w_grant;
    logic [PTRW-1:0]          w_first;
    logic [PTRW-1:0]          w_rr_nxt;
    logic                     w_found;
    int                       w_idx;

    // symmetric exclusion mask, diagonal dropped
    for (genvar gi = 0; gi < NRULES; gi++) begin : g_cm_row
        for (genvar gj = 0; gj < NRULES; gj++) begin : g_cm_col
            assign w_cm[gi*NRULES+gj] = (gi != gj) &&
                conflict_or(CMAP, NRULES, gi, gj);
        end
    end

    always_comb begin
        w_grant = '0;
        w_first = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NRULES; i++) begin
            if (w_starved[i] && rule_ready[i] &&
                ((w_cm[i*NRULES +: NRULES] & w_grant) == '0)) begin
                w_grant[i] = 1'b1;
            end
        end
        for (int k = 0; k < NRULES; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NRULES) begin
                w_idx = w_idx - NRULES;
            end
            if (!w_starved[w_idx] && rule_ready[w_idx] &&
                ((w_cm[w_idx*NRULES +: NRULES] & w_grant) == '0)) begin
                w_grant[w_idx] = 1'b1;
                if (!w_found) begin
                    w_found = 1'b1;
                    w_first = PTRW'(w_idx);
                end
            end
        end
    end

    assign rule_enable = (nRST || !run) ? '0 : w_grant;

    assign w_rr_nxt = (w_first == PTRW'(NRULES - 1)) ?
        '0 : w_first + 1'b1;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_rr_ptr <= '0;
            r_fire   <= '0;
        end else begin
            if (run && w_found) begin
                r_rr_ptr <= w_rr_nxt;
            end
            r_fire <= r_fire +
                CNTW'(popcount(SCHED_MAX_RULES'(rule_enable)));
        end
    end

    for (genvar g = 0; g < NRULES; g++) begin : g_starve
        rule_starve_ctr #(
            .STARVE_LIMIT(STARVE_LIMIT)
        ) u_ctr (
            .i_clk    (CLK),
            .i_rst    (nRST),
            .i_run    (run),
            .i_ready  (rule_ready[g]),
            .i_grant  (rule_enable[g]),
            .o_starved(w_starved[g])
        );
    end

    assign starved    = w_starved;
    assign fire_count = r_fire;

endmodule

// File: tb/tb_rule_scheduler.sv
// Bench for rule_scheduler: five parameterisations share one stimulus
// stream and are compared against a visit-order reference model.
module tb_rule_scheduler;

    localparam logic [15:0] C1 = 16'h4002;
    localparam logic [15:0] C2 = 16'hFFFF;
    localparam logic [8:0]  C3 = 9'h004;
    localparam int NU = 5;
    localparam int P_N   [NU] = '{4, 4, 4, 3, 4};
    localparam int P_LIM [NU] = '{7, 7, 2, 3, 7};
    localparam int P_W   [NU] = '{32, 32, 4, 8, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] ready;

    logic [3:0]  en [NU];
    logic [3:0]  st [NU];
    logic [31:0] fc [NU];
    logic [2:0]  en3, st3;
    logic [7:0]  fc3;
    logic [3:0]  fc2, fc4;

    int     m_rr  [NU];
    int     m_ctr [NU][4];
    longint m_fire[NU];
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;

    rule_scheduler u0 (
        .CLK(clk), .nRST(rst), .run(run), .rule_ready(ready),
        .rule_enable(en[0]), .starved(st[0]), .fire_count(fc[0])
    );

    rule_scheduler #(.CONFLICT(C1)) u1 (
        .CLK(clk), .nRST(rst), .run(run), .rule_ready(ready),
        .rule_enable(en[1]), .starved(st[1]), .fire_count(fc[1])
    );

    rule_scheduler #(.CONFLICT(C2), .STARVE_LIMIT(2), .CNTW(4)) u2 (
        .CLK(clk), .nRST(rst), .run(run), .rule_ready(ready),
        .rule_enable(en[2]), .starved(st[2]), .fire_count(fc2)
    );

    rule_scheduler #(
        .NRULES(3), .CONFLICT(C3), .STARVE_LIMIT(3), .CNTW(8)
    ) u3 (
        .CLK(clk), .nRST(rst), .run(run), .rule_ready(ready[2:0]),
        .rule_enable(en3), .starved(st3), .fire_count(fc3)
    );

    rule_scheduler #(.CNTW(4)) u4 (
        .CLK(clk), .nRST(rst), .run(run), .rule_ready(ready),
        .rule_enable(en[4]), .starved(st[4]), .fire_count(fc4)
    );

    assign fc[2] = {28'd0, fc2};
    assign en[3] = {1'b0, en3};
    assign st[3] = {1'b0, st3};
    assign fc[3] = {24'd0, fc3};
    assign fc[4] = {28'd0, fc4};

    function automatic bit m_conf(input int u, input int i, input int j);
        logic [15:0] c1;
        logic [15:0] c2;
        logic [8:0]  c3;
        c1 = C1;
        c2 = C2;
        c3 = C3;
        if (i == j) return 1'b0;
        case (u)
            1: return c1[i*4+j] || c1[j*4+i];
            2: return c2[i*4+j] || c2[j*4+i];
            3: return c3[i*3+j] || c3[j*3+i];
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        for (int u = 0; u < NU; u++) begin
            m_rr[u]   = 0;
            m_fire[u] = 0;
            for (int i = 0; i < 4; i++) m_ctr[u][i] = 0;
        end
    endtask

    task automatic step(input logic [3:0] rdy, input bit rn, input bit rs);
        int     order[$];
        int     n, i, first;
        bit     ok;
        logic [3:0] g, s;
        longint mask;
        @(negedge clk);
        ready = rdy;
        run   = rn;
        rst   = rs;
        #1;
        for (int u = 0; u < NU; u++) begin
            n = P_N[u];
            g = '0;
            s = '0;
            first = -1;
            order.delete();
            for (int k = 0; k < n; k++) begin
                if (m_ctr[u][k] == P_LIM[u]) begin
                    s[k] = 1'b1;
                    order.push_back(k);
                end
            end
            for (int k = 0; k < n; k++) begin
                i = (m_rr[u] + k) % n;
                if (!s[i]) order.push_back(i);
            end
            if (!rs && rn) begin
                foreach (order[q]) begin
                    i  = order[q];
                    ok = rdy[i];
                    for (int j = 0; j < n; j++) begin
                        if (g[j] && m_conf(u, i, j)) ok = 1'b0;
                    end
                    if (ok) begin
                        g[i] = 1'b1;
                        if (!s[i] && first < 0) first = i;
                    end
                end
            end
            n_checks++;
            assert (en[u] === g) else begin
                n_errors++;
                $error("FAIL enable u%0d got %b exp %b", u, en[u], g);
            end
            n_checks++;
            assert ((en[u] & ~rdy) === 4'b0) else begin
                n_errors++;
                $error("FAIL ena_rdy u%0d got %b exp 0000",
                       u, en[u] & ~rdy);
            end
            n_checks++;
            assert (st[u] === s) else begin
                n_errors++;
                $error("FAIL starved u%0d got %b exp %b", u, st[u], s);
            end
            n_checks++;
            assert (fc[u] === 32'(m_fire[u])) else begin
                n_errors++;
                $error("FAIL fire_count u%0d got %0d exp %0d",
                       u, fc[u], m_fire[u]);
            end
            // model state advances as the coming posedge will
            if (rs) begin
                m_rr[u]   = 0;
                m_fire[u] = 0;
                for (int k = 0; k < 4; k++) m_ctr[u][k] = 0;
            end else if (rn) begin
                for (int k = 0; k < n; k++) begin
                    if (!rdy[k] || g[k]) m_ctr[u][k] = 0;
                    else if (m_ctr[u][k] < P_LIM[u]) m_ctr[u][k]++;
                end
                mask = (64'd1 << P_W[u]) - 1;
                m_fire[u] = (m_fire[u] + $countones(g)) & mask;
                if (first >= 0) m_rr[u] = (first + 1) % n;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        run   = 1'b1;
        ready = 4'hF;
        m_reset();
        repeat (2) @(posedge clk);
        // reset held with everything ready, then release
        repeat (3) step(4'hF, 1'b1, 1'b1);
        repeat (3) step(4'hF, 1'b1, 1'b0);
        // three cycles of 1011 on a clean count
        step(4'hF, 1'b1, 1'b1);
        repeat (3) step(4'b1011, 1'b1, 1'b0);
        // pairwise conflict alternation
        repeat (6) step(4'b0011, 1'b1, 1'b0);
        // full contention, then a run=0 hold and resume
        repeat (8) step(4'hF, 1'b1, 1'b0);
        repeat (5) step(4'hF, 1'b0, 1'b0);
        repeat (6) step(4'hF, 1'b1, 1'b0);
        // narrow counter wrap
        step(4'hF, 1'b1, 1'b1);
        repeat (6) step(4'hF, 1'b1, 1'b0);
        // random traffic with occasional hold and mid-run reset
        for (int t = 0; t < 400; t++) begin
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 63) == 0));
        end
        step(4'h0, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
